// File: rtl/rv_hazard_ctrl.sv
// rtl/rv_hazard_ctrl.sv - rv32i five-stage pipeline hazard, forwarding and MDU scoreboard control
//
// Purpose: forwarding selects and stall/flush controls for the F/D/E/M/W
// pipeline, a pending-write scoreboard for the out-of-line mul/div unit,
// a data-memory freeze and saturating stall/flush event counters.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D, RdD            D-stage sources and destination
//   Rs1E, Rs2E, RdE            E-stage sources and destination
//   RdM, RdW                   M- and W-stage destinations
//   regwriteE/M/W              stage writes the register file
//   loadE                      E-stage instruction is a load
//   mduD                       D-stage instruction is an MDU op
//   mdu_startE                 MDU op issues from E this cycle
//   mdu_done, mdu_rd           MDU writeback and its destination
//   dmem_wait                  data memory not ready, freeze everything
//   PCSrcE                     taken branch/jump resolved in E
//   stallF/D/E/M               hold stage register
//   flushD/E                   bubble stage register at next edge
//   forwardAE/BE               00 regfile, 10 M result, 01 W result
//   sb_pending                 scoreboard bits
//   sb_err                     sticky: completion with nothing outstanding
//   stall_cycles, flush_events saturating performance counters

module rv_hazard_ctrl #(
    parameter int ADW      = 5,
    parameter int FWD_EN   = 1,
    parameter int MDU_OUTS = 2,
    parameter int CNTW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADW-1:0]       Rs1D,
    input  logic [ADW-1:0]       Rs2D,
    input  logic [ADW-1:0]       RdD,
    input  logic [ADW-1:0]       Rs1E,
    input  logic [ADW-1:0]       Rs2E,
    input  logic [ADW-1:0]       RdE,
    input  logic [ADW-1:0]       RdM,
    input  logic [ADW-1:0]       RdW,
    input  logic                 regwriteE,
    input  logic                 regwriteM,
    input  logic                 regwriteW,
    input  logic                 loadE,
    input  logic                 mduD,
    input  logic                 mdu_startE,
    input  logic                 mdu_done,
    input  logic [ADW-1:0]       mdu_rd,
    input  logic                 dmem_wait,
    input  logic                 PCSrcE,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 flushD,
    output logic                 flushE,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic [(2**ADW)-1:0]  sb_pending,
    output logic                 sb_err,
    output logic [CNTW-1:0]      stall_cycles,
    output logic [CNTW-1:0]      flush_events
);

    localparam int NREG = 2**ADW;

    logic [2:0]      outstanding;
    logic            rawE, rawM, dh, sh, mf;
    logic            startOk, doneOk;
    logic [NREG-1:0] sbNext;

    // x0 is hard-wired zero, so it never produces a match.
    function automatic logic regHit(input logic [ADW-1:0] a, input logic [ADW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (FWD_EN != 0) begin
            if (regwriteM && regHit(RdM, Rs1E))      forwardAE = 2'b10;
            else if (regwriteW && regHit(RdW, Rs1E)) forwardAE = 2'b01;
            if (regwriteM && regHit(RdM, Rs2E))      forwardBE = 2'b10;
            else if (regwriteW && regHit(RdW, Rs2E)) forwardBE = 2'b01;
        end
    end

    // W-stage producers never hazard: the regfile writes through to D reads.
    always_comb begin
        rawE = regwriteE && (regHit(RdE, Rs1D) || regHit(RdE, Rs2D));
        rawM = regwriteM && (regHit(RdM, Rs1D) || regHit(RdM, Rs2D));
        if (FWD_EN != 0) dh = loadE && rawE;
        else             dh = rawE || rawM;
        // RdD is included so a younger write cannot overtake a pending MDU write.
        sh = sb_pending[Rs1D] | sb_pending[Rs2D] | sb_pending[RdD];
        mf = mduD && (outstanding == 3'(MDU_OUTS));
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (dmem_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (PCSrcE) begin
            // The hazarding D instruction is on the wrong path and gets squashed.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (dh || sh || mf) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // A start during a memory freeze is not accepted; E re-presents it later.
    assign startOk = mdu_startE && !dmem_wait;
    assign doneOk  = mdu_done && (outstanding != 3'd0);

    // Set is applied after clear so a same-index start wins.
    always_comb begin
        sbNext = sb_pending;
        if (doneOk)                 sbNext[mdu_rd] = 1'b0;
        if (startOk && RdE != '0)   sbNext[RdE]    = 1'b1;
        sbNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_pending   <= '0;
            outstanding  <= 3'd0;
            sb_err       <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            sb_pending <= sbNext;
            if (startOk && !doneOk)      outstanding <= outstanding + 3'd1;
            else if (!startOk && doneOk) outstanding <= outstanding - 3'd1;
            if (mdu_done && outstanding == 3'd0) sb_err <= 1'b1;
            if (stallD && stall_cycles != '1)    stall_cycles <= stall_cycles + 1'b1;
            if (PCSrcE && !dmem_wait && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb/tb_rv_hazard_ctrl.sv - directed vector bench for rv_hazard_ctrl (forwarding and stall-only builds)

module tb_rv_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, mdu_rd;
    logic regwriteE, regwriteM, regwriteW, loadE, mduD, mdu_startE, mdu_done, dmem_wait, PCSrcE;

    logic stallF1, stallD1, stallE1, stallM1, flushD1, flushE1, sbErr1;
    logic [1:0] fA1, fB1;
    logic [31:0] sb1;
    logic [15:0] stallCnt1, flushCnt1;

    logic stallF0, stallD0, stallE0, stallM0, flushD0, flushE0, sbErr0;
    logic [1:0] fA0, fB0;
    logic [31:0] sb0;
    logic [15:0] stallCnt0, flushCnt0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_hazard_ctrl #(.ADW(5), .FWD_EN(1), .MDU_OUTS(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .mduD(mduD), .mdu_startE(mdu_startE), .mdu_done(mdu_done), .mdu_rd(mdu_rd),
        .dmem_wait(dmem_wait), .PCSrcE(PCSrcE),
        .stallF(stallF1), .stallD(stallD1), .stallE(stallE1), .stallM(stallM1),
        .flushD(flushD1), .flushE(flushE1), .forwardAE(fA1), .forwardBE(fB1),
        .sb_pending(sb1), .sb_err(sbErr1), .stall_cycles(stallCnt1), .flush_events(flushCnt1)
    );

    rv_hazard_ctrl #(.ADW(5), .FWD_EN(0), .MDU_OUTS(2), .CNTW(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .mduD(mduD), .mdu_startE(mdu_startE), .mdu_done(mdu_done), .mdu_rd(mdu_rd),
        .dmem_wait(dmem_wait), .PCSrcE(PCSrcE),
        .stallF(stallF0), .stallD(stallD0), .stallE(stallE0), .stallM(stallM0),
        .flushD(flushD0), .flushE(flushE0), .forwardAE(fA0), .forwardBE(fB0),
        .sb_pending(sb0), .sb_err(sbErr0), .stall_cycles(stallCnt0), .flush_events(flushCnt0)
    );

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwE, rwM, rwW, ld, pc, dw;
        logic [3:0] st1;   // {stallF, stallD, stallE, stallM}, forwarding build
        logic [1:0] fl1;   // {flushD, flushE}
        logic [1:0] fa, fb;
        logic [3:0] st0;   // stall-only build
        logic [1:0] fl0;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; RdD = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0; mdu_rd = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; loadE = 0; mduD = 0;
        mdu_startE = 0; mdu_done = 0; dmem_wait = 0; PCSrcE = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clr();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0, 0,0,0, 4'b0000,2'b00,2'b00,2'b00, 4'b0000,2'b00};
        vecs[1]  = '{0,0,5,0,0,5,5, 0,1,1, 0,0,0, 4'b0000,2'b00,2'b10,2'b00, 4'b0000,2'b00};
        vecs[2]  = '{0,0,5,0,0,5,5, 0,0,1, 0,0,0, 4'b0000,2'b00,2'b01,2'b00, 4'b0000,2'b00};
        vecs[3]  = '{0,0,0,5,0,5,5, 0,1,1, 0,0,0, 4'b0000,2'b00,2'b00,2'b10, 4'b0000,2'b00};
        vecs[4]  = '{0,7,0,0,7,0,0, 1,0,0, 1,0,0, 4'b1100,2'b01,2'b00,2'b00, 4'b1100,2'b01};
        vecs[5]  = '{0,7,0,0,7,0,0, 1,0,0, 0,0,0, 4'b0000,2'b00,2'b00,2'b00, 4'b1100,2'b01};
        vecs[6]  = '{3,0,0,0,0,3,0, 0,1,0, 0,0,0, 4'b0000,2'b00,2'b00,2'b00, 4'b1100,2'b01};
        vecs[7]  = '{3,0,0,0,0,0,3, 0,0,1, 0,0,0, 4'b0000,2'b00,2'b00,2'b00, 4'b0000,2'b00};
        vecs[8]  = '{0,0,0,0,0,0,0, 1,0,0, 1,0,0, 4'b0000,2'b00,2'b00,2'b00, 4'b0000,2'b00};
        vecs[9]  = '{0,7,0,0,7,0,0, 1,0,0, 1,1,0, 4'b0000,2'b11,2'b00,2'b00, 4'b0000,2'b11};
        vecs[10] = '{0,7,0,0,7,0,0, 1,0,0, 1,1,1, 4'b1111,2'b00,2'b00,2'b00, 4'b1111,2'b00};
        vecs[11] = '{0,0,0,0,0,0,0, 0,0,0, 0,0,1, 4'b1111,2'b00,2'b00,2'b00, 4'b1111,2'b00};
        vecs[12] = '{0,0,4,4,0,4,4, 0,1,1, 0,0,0, 4'b0000,2'b00,2'b10,2'b10, 4'b0000,2'b00};

        clr();
        rst_n = 1'b0;
        #12;
        chk("reset_stalls", {stallF1, stallD1, stallE1, stallM1, flushD1, flushE1}, 6'b0);
        chk("reset_fwd", {fA1, fB1}, 4'b0);
        chk("reset_sb", sb1, 32'h0);
        chk("reset_cnt", {sbErr1, stallCnt1, flushCnt1}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            clr();
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
            regwriteE = vecs[i].rwE; regwriteM = vecs[i].rwM; regwriteW = vecs[i].rwW;
            loadE = vecs[i].ld; PCSrcE = vecs[i].pc; dmem_wait = vecs[i].dw;
            #1;
            chk($sformatf("v%0d_stall_fwd", i), {stallF1, stallD1, stallE1, stallM1}, vecs[i].st1);
            chk($sformatf("v%0d_flush_fwd", i), {flushD1, flushE1}, vecs[i].fl1);
            chk($sformatf("v%0d_fwdA", i), fA1, vecs[i].fa);
            chk($sformatf("v%0d_fwdB", i), fB1, vecs[i].fb);
            chk($sformatf("v%0d_stall_noFwd", i), {stallF0, stallD0, stallE0, stallM0}, vecs[i].st0);
            chk($sformatf("v%0d_flush_noFwd", i), {flushD0, flushE0}, vecs[i].fl0);
            chk($sformatf("v%0d_fwd_noFwd", i), {fA0, fB0}, 4'b0000);
        end

        // Load-use (1 stall) vs stall-only RAW (2 stalls)
        pulse_reset();
        @(negedge clk);
        loadE = 1; regwriteE = 1; RdE = 7; Rs2D = 7;
        #1;
        chk("lu_stallD_fwd", stallD1, 1'b1);
        chk("lu_stallD_noFwd", stallD0, 1'b1);
        chk("lu_cnt_before", stallCnt1, 16'd0);
        step();
        clr(); regwriteM = 1; RdM = 7; Rs2D = 7;
        #1;
        chk("lu_m_stallD_fwd", stallD1, 1'b0);
        chk("lu_m_stallD_noFwd", stallD0, 1'b1);
        chk("lu_cnt_after1", stallCnt1, 16'd1);
        step();
        clr(); regwriteW = 1; RdW = 7; Rs2D = 7; Rs2E = 7;
        #1;
        chk("lu_w_stallD_noFwd", stallD0, 1'b0);
        chk("lu_w_fwdB", fB1, 2'b01);
        step();
        chk("lu_total_fwd", stallCnt1, 16'd1);
        chk("lu_total_noFwd", stallCnt0, 16'd2);

        // Branch beats load-use; dmem_wait beats branch
        clr(); loadE = 1; regwriteE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        #1;
        chk("br_ctrl", {stallF1, stallD1, flushD1, flushE1}, 4'b0011);
        chk("br_cnt_before", flushCnt1, 16'd0);
        step();
        chk("br_cnt_after", flushCnt1, 16'd1);
        dmem_wait = 1;
        #1;
        chk("dw_ctrl", {stallF1, stallD1, stallE1, stallM1, flushD1, flushE1}, 6'b111100);
        step();
        chk("dw_cnt", flushCnt1, 16'd1);

        // Scoreboard set/clear ordering and release timing
        pulse_reset();
        @(negedge clk);
        mdu_startE = 1; RdE = 9;
        step();
        chk("sb_set9", sb1, 32'h0000_0200);
        clr(); Rs1D = 9;
        #1;
        chk("sb_stall_pending", stallD1, 1'b1);
        mdu_startE = 1; RdE = 9; mdu_done = 1; mdu_rd = 9;
        step();
        chk("sb_set_wins", sb1, 32'h0000_0200);
        clr(); Rs1D = 9; mdu_done = 1; mdu_rd = 9;
        #1;
        chk("sb_stall_done_cycle", stallD1, 1'b1);
        step();
        clr(); Rs1D = 9;
        #1;
        chk("sb_released", stallD1, 1'b0);
        chk("sb_cleared", sb1, 32'h0);
        chk("sb_no_err", sbErr1, 1'b0);
        dmem_wait = 1; mdu_startE = 1; RdE = 10;
        step();
        chk("sb_dw_blocks_start", sb1, 32'h0);

        // MDU full, release, spurious completion
        pulse_reset();
        @(negedge clk);
        mdu_startE = 1; RdE = 11;
        step();
        RdE = 12;
        step();
        clr(); mduD = 1;
        #1;
        chk("mf_stall", stallD1, 1'b1);
        mdu_done = 1; mdu_rd = 11;
        #1;
        chk("mf_stall_done_cycle", stallD1, 1'b1);
        step();
        clr(); mduD = 1;
        #1;
        chk("mf_released", stallD1, 1'b0);
        clr(); mdu_done = 1; mdu_rd = 12;
        step();
        chk("mf_sb_empty", sb1, 32'h0);
        mdu_rd = 5;
        #1;
        chk("err_before", sbErr1, 1'b0);
        step();
        clr();
        chk("err_set", sbErr1, 1'b1);
        step();
        chk("err_sticky", sbErr1, 1'b1);

        // Asynchronous reset with MDU ops outstanding and a stall active
        pulse_reset();
        @(negedge clk);
        mdu_startE = 1; RdE = 13;
        step();
        RdE = 14; Rs1D = 13;
        step();
        clr(); Rs1D = 13; loadE = 1; regwriteE = 1; RdE = 7; Rs2D = 7;
        #1;
        chk("rst_pre_cnt", stallCnt1, 16'd1);
        chk("rst_pre_sb", sb1, 32'h0000_6000);
        rst_n = 1'b0;
        #1;
        chk("rst_sb", sb1, 32'h0);
        chk("rst_cnt", {stallCnt1, flushCnt1}, 32'h0);
        chk("rst_hazard_holds", stallD1, 1'b1);
        clr();
        #1;
        chk("rst_all_zero", {stallF1, stallD1, stallE1, stallM1, flushD1, flushE1, fA1, fB1}, 10'b0);
        rst_n = 1'b1;
        mdu_done = 1; mdu_rd = 13;
        step();
        clr();
        chk("rst_spurious_done", sbErr1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
